// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the SPI master arbiter.
`default_nettype none

package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    localparam logic [2:0]  SS_IDLE_DEFAULT = 3'b000;
    localparam logic [15:0] TIMEOUT_RD_DATA = 16'hDEAD;

    // Pointer width that stays legal for a two-requester build.
    function automatic int ptr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, first set req bit at or above rr_ptr.
`default_nettype none

module rr_picker
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any_req
);

    int               w_pos;
    logic [PTR_W-1:0] w_pos_idx;

    // Scan farthest-to-nearest so the candidate closest to rr_ptr overrides.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        w_pos      = 0;
        w_pos_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(rr_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_pos_idx = PTR_W'(w_pos);
            if (req[w_pos_idx]) begin
                winner             = '0;
                winner[w_pos_idx]  = 1'b1;
                winner_idx         = w_pos_idx;
                any_req            = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin share of one SPI master, grant held for a whole transaction.
// Optional watchdog on the WAIT phase enabled by defining SPI_ARB_TIMEOUT_EN.
`default_nettype none

module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int              NUM_REQ        = 3,
    parameter int              SS_W           = 3,
    parameter logic [SS_W-1:0] SS_IDLE        = SS_W'(SS_IDLE_DEFAULT),
    parameter int              TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*SS_W-1:0] req_ss,
    input  logic [NUM_REQ*16-1:0]   req_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [15:0]             rd_data,
    output logic                    err,
    output logic                    wrt_SPI,
    output logic [15:0]             SPI_data,
    output logic [SS_W-1:0]         ss,
    input  logic                    SPI_done,
    input  logic [15:0]             SPI_rd_data
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_win_idx;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_err;
    logic                 r_wrt_spi;
    logic [15:0]          r_spi_data;
    logic [SS_W-1:0]      r_ss;
    logic [15:0]          r_rd_data;

    logic [NUM_REQ-1:0]   w_winner;
    logic [PTR_W-1:0]     w_winner_idx;
    logic                 w_any_req;
    logic                 w_spi_done_evt;
    logic                 w_timeout;
    logic                 w_release;
    logic [PTR_W-1:0]     w_ptr_nxt;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req        (req),
        .rr_ptr     (r_rr_ptr),
        .winner     (w_winner),
        .winner_idx (w_winner_idx),
        .any_req    (w_any_req)
    );

    assign w_spi_done_evt = (r_state == WAIT) && SPI_done;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == LAUNCH) begin
            r_wd_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // A real SPI_done on the expiry cycle takes precedence over the watchdog.
    assign w_timeout = (r_state == WAIT) && !SPI_done &&
                       (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_release = w_spi_done_evt || w_timeout;
    assign w_ptr_nxt = (int'(r_win_idx) == NUM_REQ - 1) ? '0 : r_win_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = LAUNCH;
            LAUNCH:  w_state_nxt = WAIT;
            WAIT:    if (w_release) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_win_idx  <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_wrt_spi  <= 1'b0;
            r_spi_data <= '0;
            r_ss       <= SS_IDLE;
            r_rd_data  <= '0;
        end else begin
            r_done    <= '0;
            r_err     <= 1'b0;
            r_wrt_spi <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_win_idx  <= w_winner_idx;
                        r_gnt      <= w_winner;
                        r_ss       <= req_ss[int'(w_winner_idx)*SS_W +: SS_W];
                        r_spi_data <= req_data[int'(w_winner_idx)*16 +: 16];
                        r_wrt_spi  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (w_release) begin
                        r_rd_data <= w_spi_done_evt ? SPI_rd_data : TIMEOUT_RD_DATA;
                        r_done    <= r_gnt;
                        r_err     <= w_timeout;
                        r_gnt     <= '0;
                        r_ss      <= SS_IDLE;
                        r_rr_ptr  <= w_ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign err      = r_err;
    assign wrt_SPI  = r_wrt_spi;
    assign SPI_data = r_spi_data;
    assign ss       = r_ss;
    assign rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed and randomized transactions against a transaction-level model.
`default_nettype none

module tb_spi_arbiter;

    localparam int NR = 3;
    localparam int SW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*SW-1:0] req_ss;
    logic [NR*16-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    done;
    logic [15:0]      rd_data;
    logic             err;
    logic             wrt_SPI;
    logic [15:0]      SPI_data;
    logic [SW-1:0]    ss;
    logic             SPI_done;
    logic [15:0]      SPI_rd_data;

    int n_assert = 0;
    int n_fail   = 0;
    int m_ptr    = 0;

    spi_arbiter #(
        .NUM_REQ        (NR),
        .SS_W           (SW),
        .SS_IDLE        (3'b000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_ss      (req_ss),
        .req_data    (req_data),
        .gnt         (gnt),
        .done        (done),
        .rd_data     (rd_data),
        .err         (err),
        .wrt_SPI     (wrt_SPI),
        .SPI_data    (SPI_data),
        .ss          (ss),
        .SPI_done    (SPI_done),
        .SPI_rd_data (SPI_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: first requester at or after the pointer, wrapping.
    function automatic int pick(input int p, input logic [NR-1:0] r);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"},  32'(err), 0);
        chk({tag, "_wrt"},  32'(wrt_SPI), 0);
        chk({tag, "_data"}, 32'(SPI_data), 0);
        chk({tag, "_ss"},   32'(ss), 0);
        chk({tag, "_rd"},   32'(rd_data), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; SPI_done = 1'b0; SPI_rd_data = '0;
        step(); step();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // One full transaction; the next call's grant step doubles as the IDLE turnaround.
    task automatic run_xact(input logic [NR-1:0] rv, input int wcyc,
                            input logic [15:0] rdv, input bit scramble);
        int          w;
        logic [2:0]  e_ss;
        logic [15:0] e_data;
        req = rv;
        step();
        w = pick(m_ptr, rv);
        chk("done_clear", 32'(done), 0);
        if (w < 0) begin
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_wrt", 32'(wrt_SPI), 0);
            return;
        end
        e_ss   = req_ss[w*SW +: SW];
        e_data = req_data[w*16 +: 16];
        chk("gnt", 32'(gnt), 32'(1) << w);
        chk("wrt_on", 32'(wrt_SPI), 1);
        chk("ss", 32'(ss), 32'(e_ss));
        chk("spi_data", 32'(SPI_data), 32'(e_data));
        if (scramble) begin
            req = '0; req_data = {NR{16'hFFFF}}; req_ss = '1;
        end
        step();
        chk("wrt_off", 32'(wrt_SPI), 0);
        repeat (wcyc) step();
        chk("hold_gnt", 32'(gnt), 32'(1) << w);
        chk("hold_ss", 32'(ss), 32'(e_ss));
        chk("hold_data", 32'(SPI_data), 32'(e_data));
        chk("no_early_done", 32'(done), 0);
        SPI_done = 1'b1; SPI_rd_data = rdv;
        step();
        SPI_done = 1'b0;
        chk("done", 32'(done), 32'(1) << w);
        chk("rd_data", 32'(rd_data), 32'(rdv));
        chk("rel_gnt", 32'(gnt), 0);
        chk("rel_ss", 32'(ss), 0);
        chk("rel_err", 32'(err), 0);
        m_ptr = (w + 1) % NR;
    endtask

    initial begin
        logic [15:0] prev_rd;
        int          w;
        req = '0; req_ss = '0; req_data = '0;
        do_reset();
        chk_reset_outputs("reset");

        // Single request, SPI_done 40 cycles after the grant.
        req_ss[2:0] = 3'd2; req_data[15:0] = 16'h0A5C;
        run_xact(3'b001, 38, 16'h1234, 1'b0);

        // Fairness with all requesters held high.
        do_reset();
        req_ss = 9'($urandom); req_data = 48'({$urandom, $urandom});
        for (int i = 0; i < 6; i++) begin
            run_xact(3'b111, 8, 16'($urandom), 1'b0);
        end

        // Winner drops req and changes its data after the grant.
        run_xact(3'b010, 5, 16'h7E57, 1'b1);

        // Back-to-back single requester.
        run_xact(3'b100, 3, 16'h0001, 1'b0);
        run_xact(3'b100, 3, 16'h0002, 1'b0);

        // Spurious SPI_done in IDLE.
        req = '0; prev_rd = rd_data;
        SPI_done = 1'b1; SPI_rd_data = 16'hBEEF;
        step();
        SPI_done = 1'b0;
        chk("spur_idle_done", 32'(done), 0);
        chk("spur_idle_rd", 32'(rd_data), 32'(prev_rd));
        chk("spur_idle_gnt", 32'(gnt), 0);

        // Spurious SPI_done in LAUNCH.
        req_ss = 9'($urandom); req_data = 48'({$urandom, $urandom});
        req = 3'b011;
        w = pick(m_ptr, req);
        step();
        req = '0;
        chk("spur_l_gnt", 32'(gnt), 32'(1) << w);
        SPI_done = 1'b1; SPI_rd_data = 16'hBAD0;
        step();
        SPI_done = 1'b0;
        step();
        chk("spur_l_done", 32'(done), 0);
        chk("spur_l_hold", 32'(gnt), 32'(1) << w);
        SPI_done = 1'b1; SPI_rd_data = 16'h600D;
        step();
        SPI_done = 1'b0;
        chk("spur_l_real_done", 32'(done), 32'(1) << w);
        chk("spur_l_rd", 32'(rd_data), 32'h600D);
        m_ptr = (w + 1) % NR;

        // Reset in the middle of WAIT.
        step();
        req = 3'b010;
        step(); step(); step();
        chk("mid_gnt", 32'(gnt), 32'b010);
        rst = 1'b1; req = '0;
        step();
        rst = 1'b0;
        m_ptr = 0;
        chk_reset_outputs("mid_reset");
        run_xact(3'b110, 4, 16'hA1A1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            req_ss = 9'($urandom); req_data = 48'({$urandom, $urandom});
            run_xact(3'($urandom_range(0, 7)), $urandom_range(0, 6),
                     16'($urandom), 1'($urandom_range(0, 1)));
        end

`ifdef SPI_ARB_TIMEOUT_EN
        // Watchdog expiry after 16 WAIT cycles.
        step();
        req = 3'b001;
        w = pick(m_ptr, req);
        step();
        req = '0;
        repeat (16) step();
        chk("to_pre_err", 32'(err), 0);
        step();
        chk("to_err", 32'(err), 1);
        chk("to_done", 32'(done), 32'(1) << w);
        chk("to_rd", 32'(rd_data), 32'hDEAD);
        chk("to_gnt", 32'(gnt), 0);
        m_ptr = (w + 1) % NR;
        step();
        chk("to_err_pulse", 32'(err), 0);

        // SPI_done on the expiry cycle completes normally.
        req = 3'b001;
        w = pick(m_ptr, req);
        step();
        req = '0;
        repeat (16) step();
        SPI_done = 1'b1; SPI_rd_data = 16'h5555;
        step();
        SPI_done = 1'b0;
        chk("to_race_err", 32'(err), 0);
        chk("to_race_done", 32'(done), 32'(1) << w);
        chk("to_race_rd", 32'(rd_data), 32'h5555);
        m_ptr = (w + 1) % NR;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
